// File: rtl/spi_wrapper_pkg.sv
// Shared types and constants for the SPI wrapper front end.
package spi_wrapper_pkg;

  localparam int unsigned FRAME_W_DEF = 10;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if_if.sv
// Signal bundle between the SPI pins/RAM and spi_slave_if.
// frame_err exists only when SPI_FRAME_ERR_EN is defined.
interface spi_slave_if_if #(
  parameter int unsigned FRAME_W = spi_wrapper_pkg::FRAME_W_DEF,
  parameter int unsigned DATA_W  = spi_wrapper_pkg::DATA_W_DEF
) ();

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic               frame_err;
`endif

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
`ifdef SPI_FRAME_ERR_EN
    , output frame_err
`endif
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
`ifdef SPI_FRAME_ERR_EN
    , input frame_err
`endif
  );

endinterface

// File: rtl/spi_miso_serializer.sv
// Latches RAM read data on load and shifts it out MSB first on MISO, one bit per cycle.
module spi_miso_serializer #(
  parameter int unsigned DATA_W = spi_wrapper_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_miso;

  // Last bit is on the wire when the counter reaches zero.
  assign o_done = r_busy && (r_cnt == '0) && !i_clear;
  assign o_busy = r_busy;
  assign o_miso = r_miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_miso  <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_miso <= 1'b0;
    end else if (i_load) begin
      r_miso  <= i_data[DATA_W-1];
      r_shift <= {i_data[DATA_W-2:0], 1'b0};
      r_cnt   <= CNT_W'(DATA_W - 1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_miso  <= r_shift[DATA_W-1];
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_cnt   <= r_cnt - 1'b1;
      end else begin
        r_miso <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: frame FSM, MOSI deserialiser and read-pair tracking.
// Optional frame_err output enabled by defining SPI_FRAME_ERR_EN.
module spi_slave_if #(
  parameter int unsigned FRAME_W = spi_wrapper_pkg::FRAME_W_DEF,
  parameter int unsigned DATA_W  = spi_wrapper_pkg::DATA_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  spi_slave_if_if.slave bus
);
  import spi_wrapper_pkg::*;

  localparam int unsigned     CNT_W    = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W + 1);

  spi_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_rd_addr_seen;
  logic               r_tx_taken;

  logic w_abort;
  logic w_load;
  logic w_ser_miso;
  logic w_ser_busy;
  logic w_ser_done;

  assign w_abort = (r_state != IDLE) && bus.SS_n;
  // RAM data is only accepted once per read-data frame, after its rx_valid.
  assign w_load  = (r_state == READ_DATA) && (r_cnt == CNT_DONE) && bus.tx_valid &&
                   !r_tx_taken && !w_ser_busy && !bus.SS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_taken     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!bus.SS_n) begin
              r_state    <= CHK_CMD;
              r_cnt      <= '0;
              r_tx_taken <= 1'b0;
            end
          end
          CHK_CMD: begin
            r_shift <= {r_shift[FRAME_W-2:0], bus.MOSI};
            r_cnt   <= CNT_W'(1);
            if (!bus.MOSI)          r_state <= WRITE;
            else if (r_rd_addr_seen) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          default: begin
            if (r_cnt < CNT_FULL) begin
              r_shift <= {r_shift[FRAME_W-2:0], bus.MOSI};
              r_cnt   <= r_cnt + 1'b1;
            end else if (r_cnt == CNT_FULL) begin
              r_cnt      <= CNT_DONE;
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_shift;
              if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
            end
            if (w_load)     r_tx_taken     <= 1'b1;
            if (w_ser_done) r_rd_addr_seen <= 1'b0;
          end
        endcase
      end
    end
  end

  spi_miso_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_clear (w_abort),
    .i_data  (bus.tx_data),
    .o_miso  (w_ser_miso),
    .o_busy  (w_ser_busy),
    .o_done  (w_ser_done)
  );

  assign bus.MISO     = w_ser_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

`ifdef SPI_FRAME_ERR_EN
  logic r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_abort && ((r_cnt != CNT_DONE) || w_ser_busy)) begin
        r_frame_err <= 1'b1;
      end else if (!w_abort && (r_state == READ_DATA) && (r_cnt == CNT_W'(1)) &&
                   !bus.MOSI) begin
        // Read-data route chosen but the command's low bit says otherwise.
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized self-checking bench for spi_slave_if against a transaction-level model.
module tb_spi_slave_if;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   rv_cnt;
  int   miso_ones;
  int   fe_cnt;
  logic m_rd_seen;
  logic [9:0] last_rx;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) rv_cnt++;
    if (bus.MISO) miso_ones++;
`ifdef SPI_FRAME_ERR_EN
    if (bus.frame_err) fe_cnt++;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SS_n-low window: send abort_bits bits (10 = full frame), then offer d on tx_valid.
  // abort_shift in 1..7 raises SS_n after that many MISO bits of a read-data reply.
  task automatic txn(input logic [9:0] f, input int abort_bits, input int abort_shift,
                     input logic [7:0] d);
    int route;
    int rv0, mo0, fe0, exp_fe, n;
    logic complete;
    logic [7:0] got, mask;
    route    = !f[9] ? 0 : (m_rd_seen ? 2 : 1);
    complete = (abort_bits >= 10);
    rv0 = rv_cnt; mo0 = miso_ones; fe0 = fe_cnt;
    exp_fe = (complete ? 0 : 1) + ((route == 2 && abort_bits >= 2 && !f[8]) ? 1 : 0);
    got = '0;
    bus.SS_n = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == abort_bits) break;
      bus.MOSI     = f[9-i];
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      step();
    end
    bus.tx_valid = 1'b0;
    bus.MOSI     = 1'b0;
    if (complete) begin
      check_eq("rv_before_12", 32'(bus.rx_valid), 32'd0);
      step();
      check_eq("rv_at_12", 32'(bus.rx_valid), 32'd1);
      check_eq("rx_data", 32'(bus.rx_data), 32'(f));
      last_rx = f;
      if (route == 1) m_rd_seen = 1'b1;
      repeat ($urandom_range(0, 3)) step();
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      step();
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      if (route == 2) begin
        n = (abort_shift > 0 && abort_shift < 8) ? abort_shift : 8;
        for (int j = 0; j < n; j++) begin
          got[7-j] = bus.MISO;
          step();
        end
        mask = 8'hFF << (8 - n);
        check_eq("miso_bits", 32'(got & mask), 32'(d & mask));
        if (n == 8) begin
          check_eq("miso_tail", 32'(bus.MISO), 32'd0);
          m_rd_seen = 1'b0;
        end else begin
          exp_fe++;
          bus.SS_n = 1'b1;
          step();
        end
      end else begin
        repeat (9) step();
      end
    end
    bus.SS_n = 1'b1;
    step();
    step();
    check_eq("miso_idle", 32'(bus.MISO), 32'd0);
    check_eq("rv_pulses", 32'(rv_cnt - rv0), complete ? 32'd1 : 32'd0);
    check_eq("rx_hold", 32'(bus.rx_data), 32'(last_rx));
    if (!(complete && route == 2)) check_eq("miso_quiet", 32'(miso_ones - mo0), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check_eq("frame_err", 32'(fe_cnt - fe0), 32'(exp_fe));
`endif
  endtask

  initial begin
    n_checks = 0; n_pass = 0; rv_cnt = 0; miso_ones = 0; fe_cnt = 0;
    m_rd_seen = 1'b0; last_rx = '0;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_miso", 32'(bus.MISO), 32'd0);
    check_eq("rst_rv", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write pair
    txn(10'h035, 10, 0, 8'($urandom));
    txn(10'h1AA, 10, 0, 8'($urandom));

    // Reset in the middle of a write frame
    bus.SS_n = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.MOSI = i[0];
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_miso", 32'(bus.MISO), 32'd0);
    check_eq("midrst_rv", 32'(bus.rx_valid), 32'd0);
    check_eq("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    bus.SS_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    m_rd_seen = 1'b0;
    last_rx = '0;

    // Read pair
    txn(10'h207, 10, 0, 8'($urandom));
    txn(10'h3A5, 10, 0, 8'hC3);

    // Aborted write frame
    txn(10'h0F3, 5, 0, 8'($urandom));

    // Flag sequencing across an aborted MISO shift
    txn(10'h2F0, 10, 0, 8'($urandom));
    txn(10'h35A, 10, 3, 8'h96);
    txn(10'h3C3, 10, 0, 8'h5A);
    txn(10'h311, 10, 0, 8'hE7);

    for (int k = 0; k < 30; k++) begin
      txn(10'($urandom),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
          8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
